// File: rtl/sa_cache_if.sv
// sa_cache_if: groups the CPU memory-stage, tag/data array, LRU queue and
// main-memory signals seen by the set-associative cache controller.
// The master modport is the controller; the slave modport is everything
// around it (CPU, arrays, LRU queue, memory port).
interface sa_cache_if #(
    parameter int ADDR_W = 32
);
    // CPU side
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ready;

    // Tag/data arrays and LRU queue
    logic [3:0]        tag_hit;
    logic [1:0]        lru_way;
    logic              victim_valid;
    logic              victim_dirty;
    logic [ADDR_W-1:0] victim_addr;
    logic [1:0]        way_sel;
    logic              lru_we;
    logic [1:0]        lru_in;
    logic              data_we;
    logic              dirty_set;
    logic              fill_we;

    // Main-memory port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;

    modport master (
        input  cpu_req, cpu_we, cpu_addr,
        input  tag_hit, lru_way, victim_valid, victim_dirty, victim_addr,
        input  mem_ack,
        output cpu_ready,
        output way_sel, lru_we, lru_in, data_we, dirty_set, fill_we,
        output mem_req, mem_we, mem_addr
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr,
        output tag_hit, lru_way, victim_valid, victim_dirty, victim_addr,
        output mem_ack,
        input  cpu_ready,
        input  way_sel, lru_we, lru_in, data_we, dirty_set, fill_we,
        input  mem_req, mem_we, mem_addr
    );
endinterface

// File: rtl/sa_cache_ctrl.sv
// sa_cache_ctrl: controller for a 4-way set-associative data cache.
// Sequences lookup, dirty-victim writeback, line fill and replay, and drives
// the per-set LRU queue update once per completed CPU access.
// Optional build macro SA_CACHE_PERF_EN adds saturating hit/miss counters.
module sa_cache_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    sa_cache_if.master bus
`ifdef SA_CACHE_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } state_e;

    localparam logic [ADDR_W-1:0] OFFSET_MASK =
        {{(ADDR_W-OFFSET_W){1'b0}}, {OFFSET_W{1'b1}}};

    state_e     state_q, state_d;
    logic [1:0] victim_q, victim_d;
    logic       replay_q, replay_d;

    logic       hit;
    logic [1:0] hit_way;

    // Hit detect; a multi-way match resolves to the lowest way.
    always_comb begin
        hit     = |bus.tag_hit;
        hit_way = 2'd0;
        if (bus.tag_hit[0])      hit_way = 2'd0;
        else if (bus.tag_hit[1]) hit_way = 2'd1;
        else if (bus.tag_hit[2]) hit_way = 2'd2;
        else if (bus.tag_hit[3]) hit_way = 2'd3;
    end

    // Next state and output decode; strobes depend on same-cycle tag/ack inputs.
    always_comb begin
        state_d       = state_q;
        victim_d      = victim_q;
        replay_d      = replay_q;
        bus.cpu_ready = 1'b0;
        bus.way_sel   = 2'd0;
        bus.lru_we    = 1'b0;
        bus.lru_in    = 2'd0;
        bus.data_we   = 1'b0;
        bus.dirty_set = 1'b0;
        bus.fill_we   = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    bus.way_sel   = hit_way;
                    bus.lru_we    = 1'b1;
                    bus.lru_in    = hit_way;
                    bus.data_we   = bus.cpu_we;
                    bus.dirty_set = bus.cpu_we;
                    bus.cpu_ready = 1'b1;
                    replay_d      = 1'b0;
                    state_d       = IDLE;
                end else begin
                    bus.way_sel = bus.lru_way;
                    victim_d    = bus.lru_way;
                    if (bus.victim_valid && bus.victim_dirty) state_d = WRITEBACK;
                    else                                      state_d = FILL;
                end
            end
            WRITEBACK: begin
                bus.way_sel  = victim_q;
                bus.mem_req  = 1'b1;
                bus.mem_we   = 1'b1;
                bus.mem_addr = bus.victim_addr;
                if (bus.mem_ack) state_d = FILL;
            end
            FILL: begin
                bus.way_sel  = victim_q;
                bus.mem_req  = 1'b1;
                bus.mem_addr = bus.cpu_addr & ~OFFSET_MASK;
                if (bus.mem_ack) begin
                    bus.fill_we = 1'b1;
                    replay_d    = 1'b1;
                    state_d     = LOOKUP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, victim way and replay flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            victim_q <= 2'd0;
            replay_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            replay_q <= replay_d;
        end
    end

`ifdef SA_CACHE_PERF_EN
    // Saturating counters: first-time hits and lookup misses; replays count as neither.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else if (state_q == LOOKUP) begin
            if (hit && !replay_q && (hit_count != 32'hFFFF_FFFF))
                hit_count <= hit_count + 32'd1;
            if (!hit && (miss_count != 32'hFFFF_FFFF))
                miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sa_cache_ctrl.sv
// tb_sa_cache_ctrl: self-checking bench for sa_cache_ctrl.
// The bench plays CPU, tag arrays, LRU queue and memory. For every access it
// predicts the observable cycle sequence (hit -> ready next cycle; miss ->
// optional writeback, fill, replay hit) and compares every cycle.
`timescale 1ns/1ps
module tb_sa_cache_ctrl;

    localparam int ADDR_W = 32;

    typedef struct packed {
        logic        cpuReady;
        logic [1:0]  waySel;
        logic        lruWe;
        logic [1:0]  lruIn;
        logic        dataWe;
        logic        dirtySet;
        logic        fillWe;
        logic        memReq;
        logic        memWe;
        logic [31:0] memAddr;
    } outs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    sa_cache_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef SA_CACHE_PERF_EN
    logic [31:0] hitCount, missCount;
    int expHits = 0;
    int expMisses = 0;
`endif

    sa_cache_ctrl #(.ADDR_W(ADDR_W), .OFFSET_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef SA_CACHE_PERF_EN
        ,
        .hit_count  (hitCount),
        .miss_count (missCount)
`endif
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Build an expected output vector.
    function automatic outs_t mk(input logic rdy, input logic [1:0] way, input logic lwe,
                                 input logic [1:0] lin, input logic dwe, input logic dset,
                                 input logic fwe, input logic mreq, input logic mwe,
                                 input logic [31:0] maddr);
        outs_t e;
        e.cpuReady = rdy;  e.waySel = way;   e.lruWe = lwe;  e.lruIn = lin;
        e.dataWe = dwe;    e.dirtySet = dset; e.fillWe = fwe; e.memReq = mreq;
        e.memWe = mwe;     e.memAddr = maddr;
        return e;
    endfunction

    // Sample DUT outputs; don't-care fields (address with no request, LRU way with no write) are masked.
    function automatic outs_t observe(input outs_t e);
        outs_t o;
        o.cpuReady = bus.cpu_ready;  o.waySel = bus.way_sel;
        o.lruWe    = bus.lru_we;     o.lruIn  = e.lruWe ? bus.lru_in : 2'd0;
        o.dataWe   = bus.data_we;    o.dirtySet = bus.dirty_set;
        o.fillWe   = bus.fill_we;    o.memReq = bus.mem_req;
        o.memWe    = bus.mem_we;     o.memAddr = e.memReq ? bus.mem_addr : 32'h0;
        return o;
    endfunction

    // Drive one complete CPU access and check every cycle against the predicted sequence.
    task automatic applyAccess(input string tag, input logic we, input logic [31:0] addr,
                               input logic [3:0] hitVec, input logic [1:0] lru,
                               input logic vv, input logic vd, input logic [31:0] vaddr,
                               input int wbDelay, input int fillDelay);
        outs_t e, o;
        int lruPulses = 0;
        int readyPulses = 0;
        logic [1:0] hw = 2'd0;
        logic [31:0] fillAddr = (addr >> 4) << 4;
        for (int i = 3; i >= 0; i--) if (hitVec[i]) hw = 2'(i);

        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.tag_hit = hitVec;
        bus.lru_way = lru; bus.victim_valid = vv; bus.victim_dirty = vd;
        bus.victim_addr = vaddr; bus.mem_ack = 1'b0;
        #1;
        e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0); o = observe(e); checks++;
        if (o !== e) begin errors++; $display("[TB] FAIL %s idle: got %h expected %h", tag, o, e); end
        if (o.lruWe) lruPulses++;
        if (o.cpuReady) readyPulses++;

        @(posedge clk); #1; bus.cpu_req = 1'b0; #1;
        if (hitVec != 4'h0) e = mk(1, hw, 1, hw, we, we, 0, 0, 0, 32'h0);
        else                e = mk(0, lru, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        o = observe(e); checks++;
        if (o !== e) begin errors++; $display("[TB] FAIL %s lookup: got %h expected %h", tag, o, e); end
        if (o.lruWe) lruPulses++;
        if (o.cpuReady) readyPulses++;

        if (hitVec == 4'h0) begin
            if (vv && vd) begin
                for (int i = 0; i <= wbDelay; i++) begin
                    @(posedge clk); #1; bus.mem_ack = (i == wbDelay); #1;
                    e = mk(0, lru, 0, 0, 0, 0, 0, 1, 1, vaddr); o = observe(e); checks++;
                    if (o !== e) begin errors++; $display("[TB] FAIL %s writeback: got %h expected %h", tag, o, e); end
                    if (o.lruWe) lruPulses++;
                    if (o.cpuReady) readyPulses++;
                end
            end
            for (int i = 0; i <= fillDelay; i++) begin
                @(posedge clk); #1; bus.mem_ack = (i == fillDelay); #1;
                e = mk(0, lru, 0, 0, 0, 0, (i == fillDelay), 1, 0, fillAddr); o = observe(e); checks++;
                if (o !== e) begin errors++; $display("[TB] FAIL %s fill: got %h expected %h", tag, o, e); end
                if (o.lruWe) lruPulses++;
                if (o.cpuReady) readyPulses++;
            end
            // The filled way now matches the address.
            @(posedge clk); #1; bus.mem_ack = 1'b0; bus.tag_hit = 4'b0001 << lru; #1;
            e = mk(1, lru, 1, lru, we, we, 0, 0, 0, 32'h0); o = observe(e); checks++;
            if (o !== e) begin errors++; $display("[TB] FAIL %s replay: got %h expected %h", tag, o, e); end
            if (o.lruWe) lruPulses++;
            if (o.cpuReady) readyPulses++;
        end

        @(posedge clk); #2;
        e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0); o = observe(e); checks++;
        if (o !== e) begin errors++; $display("[TB] FAIL %s done: got %h expected %h", tag, o, e); end
        if (o.lruWe) lruPulses++;
        if (o.cpuReady) readyPulses++;

        checks++;
        if (lruPulses != 1 || readyPulses != 1) begin
            errors++;
            $display("[TB] FAIL %s pulses: got lru_we=%0d cpu_ready=%0d expected 1/1", tag, lruPulses, readyPulses);
        end
`ifdef SA_CACHE_PERF_EN
        if (hitVec != 4'h0) expHits++; else expMisses++;
        checks++;
        if (hitCount !== 32'(expHits) || missCount !== 32'(expMisses)) begin
            errors++;
            $display("[TB] FAIL %s perf: got %0d/%0d expected %0d/%0d", tag, hitCount, missCount, expHits, expMisses);
        end
`endif
    endtask

    // Outputs stay low through reset even with a request pending.
    task automatic test_reset();
        outs_t e, o;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0; bus.tag_hit = 4'hF;
        bus.lru_way = 2'd0; bus.victim_valid = 1'b0; bus.victim_dirty = 1'b0;
        bus.victim_addr = 32'h0; bus.mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0); o = observe(e); checks++;
        if (o !== e) begin errors++; $display("[TB] FAIL reset: got %h expected %h", o, e); end
`ifdef SA_CACHE_PERF_EN
        checks++;
        if (hitCount !== 32'd0 || missCount !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_perf: got %0d/%0d expected 0/0", hitCount, missCount);
        end
`endif
        bus.cpu_req = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic test_hits();
        applyAccess("load_hit", 1'b0, 32'h0000_0040, 4'b0100, 2'd0, 1'b1, 1'b0, 32'h0, 0, 0);
        applyAccess("store_multi_hit", 1'b1, 32'h0000_0104, 4'b1010, 2'd3, 1'b1, 1'b1, 32'h0, 0, 0);
    endtask

    task automatic test_misses();
        applyAccess("clean_miss", 1'b0, 32'h0000_1234, 4'b0000, 2'd3, 1'b1, 1'b0, 32'h0000_5550, 0, 2);
        applyAccess("dirty_miss", 1'b1, 32'h0000_2468, 4'b0000, 2'd0, 1'b1, 1'b1, 32'h0000_8880, 1, 0);
        applyAccess("invalid_dirty_victim", 1'b0, 32'hABCD_EF0F, 4'b0000, 2'd1, 1'b0, 1'b1, 32'h0000_7770, 0, 1);
    endtask

    // Reset while a fill is outstanding, with an ack arriving, then a stray ack in IDLE.
    task automatic test_reset_mid_fill();
        outs_t e, o;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_3338; bus.tag_hit = 4'h0;
        bus.lru_way = 2'd2; bus.victim_valid = 1'b1; bus.victim_dirty = 1'b0; bus.mem_ack = 1'b0;
        @(posedge clk); #1; bus.cpu_req = 1'b0;
        @(posedge clk); #2;
        e = mk(0, 2, 0, 0, 0, 0, 0, 1, 0, 32'h0000_3330); o = observe(e); checks++;
        if (o !== e) begin errors++; $display("[TB] FAIL mid_fill: got %h expected %h", o, e); end
        #1; bus.mem_ack = 1'b1; rst_n = 1'b0; #1;
        e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0); o = observe(e); checks++;
        if (o !== e) begin errors++; $display("[TB] FAIL async_reset: got %h expected %h", o, e); end
`ifdef SA_CACHE_PERF_EN
        expHits = 0; expMisses = 0;
`endif
        #1; rst_n = 1'b1;
        @(posedge clk); #2;
        o = observe(e); checks++;
        if (o !== e) begin errors++; $display("[TB] FAIL stray_ack: got %h expected %h", o, e); end
        bus.mem_ack = 1'b0;
        @(posedge clk); #2;
        o = observe(e); checks++;
        if (o !== e) begin errors++; $display("[TB] FAIL stray_ack_after: got %h expected %h", o, e); end
        applyAccess("after_reset", 1'b1, 32'h0000_3338, 4'b0000, 2'd2, 1'b1, 1'b1, 32'h0000_9990, 0, 1);
    endtask

    // Randomized back-to-back accesses, mixing hits, multi-hits and all miss kinds.
    task automatic test_back_to_back();
        for (int n = 0; n < 40; n++) begin
            logic        we    = 1'($urandom_range(0, 1));
            logic [31:0] addr  = $urandom;
            logic [3:0]  hv    = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            logic [1:0]  lru   = 2'($urandom_range(0, 3));
            logic        vv    = 1'($urandom_range(0, 1));
            logic        vd    = 1'($urandom_range(0, 1));
            logic [31:0] vaddr = $urandom & 32'hFFFF_FFF0;
            applyAccess($sformatf("rand%0d", n), we, addr, hv, lru, vv, vd, vaddr,
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_hits();
        test_misses();
        test_reset_mid_fill();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sa_cache_ctrl.md
Name: sa_cache_ctrl

Overview:
Controller for the 4-way set-associative data cache. Sequences CPU lookups, dirty-victim writeback, line fill and replay. Takes victim selection from the per-set 2-bit LRU priority queue and drives that queue's update (we/in) on every completed access. Sits between the CPU memory stage, the tag/data arrays and the main-memory port.

Parameters:
ADDR_W, 32, CPU/memory byte address width
OFFSET_W, 4, block offset bits; fill address has these bits zeroed

Ports:
CLK  in  1  system clock, all state updates on posedge
RST_N  in  1  reset, asynchronous, active-low
cpu_req  in  1  access request; cpu_addr/cpu_we held stable until cpu_ready
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  ADDR_W  access address, also indexes tag/data arrays
cpu_ready  out  1  one-cycle pulse: access complete
tag_hit  in  4  per-way tag match and valid, combinational from cpu_addr
lru_way  in  2  LRU way of the indexed set, from the LRU queue
victim_valid  in  1  valid bit of the way selected by way_sel
victim_dirty  in  1  dirty bit of the way selected by way_sel
victim_addr  in  ADDR_W  block address of the way selected by way_sel
way_sel  out  2  way driven to tag/data arrays
lru_we  out  1  LRU queue write enable
lru_in  out  2  way reported as most recently used
data_we  out  1  store-hit word write into way_sel
dirty_set  out  1  set dirty bit of way_sel
fill_we  out  1  write fill line, tag and valid into way_sel; clears dirty
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = writeback, 0 = fill read
mem_addr  out  ADDR_W  block-aligned memory address
mem_ack  in  1  memory transfer complete (single-cycle pulse)

Behaviour:
- States: IDLE, LOOKUP, WRITEBACK, FILL. Reset (RST_N=0, any time, asynchronously) -> IDLE. All outputs 0. Victim register 0. Replay flag 0. Any in-flight memory transaction is abandoned.
- IDLE: cpu_req=1 -> LOOKUP next cycle. No outputs asserted.
- LOOKUP, hit (|tag_hit):
  - way_sel = index of lowest set bit of tag_hit (multi-hit resolves to lowest way).
  - lru_we=1, lru_in=way_sel.
  - If cpu_we: data_we=1 and dirty_set=1.
  - cpu_ready=1 this cycle. Clear replay flag. -> IDLE.
  - Hit latency: cpu_ready is high 1 cycle after the cycle in which cpu_req was sampled.
- LOOKUP, miss:
  - Latch victim = lru_way. No write strobes.
  - way_sel = lru_way this cycle. victim_valid and victim_dirty are evaluated combinationally against it.
  - victim_valid & victim_dirty -> WRITEBACK; otherwise -> FILL.
- WRITEBACK: way_sel=victim, mem_req=1, mem_we=1, mem_addr=victim_addr. Outputs held until mem_ack, then -> FILL.
- FILL: way_sel=victim, mem_req=1, mem_we=0, mem_addr = cpu_addr with low OFFSET_W bits zeroed.
  - On mem_ack: fill_we=1 that cycle, set replay flag, -> LOOKUP. The replay then hits and performs the LRU update and store.
- mem_ack outside WRITEBACK/FILL is ignored. mem_req deasserts the cycle after mem_ack.
- cpu_req is sampled only in IDLE. cpu_req dropping mid-access does not abort the access.
- lru_we never asserts except on a LOOKUP hit: exactly one LRU update per CPU access.
- A miss on a set whose victim is invalid skips WRITEBACK regardless of victim_dirty.

Optional Feature:
SA_CACHE_PERF_EN: adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0 and saturating at 0xFFFFFFFF.
- hit_count increments on a LOOKUP hit with replay flag clear.
- miss_count increments on each LOOKUP miss.
- A replay hit increments neither.
Without the macro: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load hit: tag_hit=4'b0100, cpu_we=0 -> next cycle way_sel=2, lru_we=1, lru_in=2, cpu_ready=1, data_we=0; back in IDLE.
- Store hit with multi-hit: tag_hit=4'b1010, cpu_we=1 -> way_sel=1, data_we=1, dirty_set=1, lru_in=1, one cpu_ready pulse.
- Clean miss: tag_hit=0, lru_way=3, victim_valid=1, victim_dirty=0, cpu_addr=0x0000_1234 -> FILL with mem_we=0, mem_addr=0x0000_1230, way_sel=3. After mem_ack (3 cycles) -> fill_we=1, then replay with tag_hit=4'b1000 -> cpu_ready, lru_in=3.
- Dirty miss: lru_way=0, victim_valid=1, victim_dirty=1, victim_addr=0x0000_8880 -> WRITEBACK with mem_we=1, mem_addr=0x0000_8880. After mem_ack -> FILL, mem_we=0. Total one lru_we pulse.
- Reset mid-FILL: RST_N low while mem_req=1 -> mem_req, fill_we, cpu_ready drop immediately. After release, IDLE; a new request behaves normally. Stray mem_ack in IDLE has no effect.
- SA_CACHE_PERF_EN: 2 hits, 1 dirty miss + replay -> hit_count=2, miss_count=1.
